// File: rtl/nvram_restore.sv
// Replays a hiscore dump downloaded on ioctl_index == DUMPINDEX into game NVRAM while the CPU is
// paused. Define NVRAM_RESTORE_VERIFY_EN to add read-back verification after every write.
module nvram_restore #(
  parameter int unsigned DUMPWIDTH  = 8,
  parameter int unsigned DUMPINDEX  = 4,
  parameter int unsigned PAUSEPAD   = 4,
  parameter int unsigned STARTDELAY = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 paused,
  input  logic                 ioctl_download,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_index,
  input  logic [7:0]           ioctl_dout,
  output logic [DUMPWIDTH-1:0] nvram_address,
  output logic [7:0]           nvram_data_in,
  output logic                 nvram_write,
  input  logic [7:0]           nvram_data_out,
  output logic                 pause_cpu,
  output logic                 restore_done,
  output logic                 verify_error
);

  localparam int unsigned    Depth     = 2 ** DUMPWIDTH;
  localparam logic [15:0]    DelayLoad = 16'(STARTDELAY);
  localparam logic [15:0]    PadLoad   = (PAUSEPAD == 0) ? 16'd0 : 16'(PAUSEPAD - 1);
  localparam logic [DUMPWIDTH:0]   LenOne = 1;
  localparam logic [DUMPWIDTH-1:0] IdxOne = 1;

  typedef enum logic [3:0] {
    StIdle, StDelay, StHalt, StRead, StWrite, StVerify, StCheck, StNext, StRelease
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          timer_q, timer_d;
  logic [DUMPWIDTH-1:0] idx_q, idx_d;
  logic                 done_q, done_set;

  // Buffer, length and arming survive core reset so an unfinished restore is retried.
  logic [7:0]           buffer [Depth];
  logic [7:0]           buf_q;
  logic [DUMPWIDTH:0]   dump_length_q = '0;
  logic                 pending_q     = 1'b0;
  logic                 dl_q          = 1'b0;
  logic [7:0]           index_q       = 8'd0;

  logic                 dl_active, dl_active_q, dl_start, dl_end;
  logic                 addr_ok, ram_we;
  logic [DUMPWIDTH-1:0] ram_addr;
  logic [DUMPWIDTH:0]   wr_len, base_len;

  assign dl_active   = ioctl_download && (ioctl_index == 8'(DUMPINDEX));
  assign dl_active_q = dl_q && (index_q == 8'(DUMPINDEX));
  assign dl_start    = dl_active && !dl_active_q;
  assign dl_end      = dl_q && !ioctl_download && (index_q == 8'(DUMPINDEX));
  assign addr_ok     = (ioctl_addr >> DUMPWIDTH) == '0;
  assign ram_we      = dl_active && ioctl_wr && addr_ok;
  assign ram_addr    = dl_active ? ioctl_addr[DUMPWIDTH-1:0] : idx_q;
  assign wr_len      = {1'b0, ioctl_addr[DUMPWIDTH-1:0]} + LenOne;
  assign base_len    = dl_start ? '0 : dump_length_q;

  always_ff @(posedge clk) begin
    if (ram_we) buffer[ram_addr] <= ioctl_dout;
    buf_q   <= buffer[ram_addr];
    dl_q    <= ioctl_download;
    index_q <= ioctl_index;
    if (ram_we && (wr_len > base_len)) dump_length_q <= wr_len;
    else if (dl_start)                 dump_length_q <= '0;
    if (dl_start)                                pending_q <= 1'b0;
    else if (dl_end && (dump_length_q != '0))    pending_q <= 1'b1;
    else if (done_set)                           pending_q <= 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    done_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (pending_q && !ioctl_download) begin
          timer_d = DelayLoad;
          state_d = StDelay;
        end
      end
      StDelay: begin
        if (timer_q == '0) begin
          timer_d = PadLoad;
          state_d = StHalt;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      StHalt: begin
        if (!paused) begin
          timer_d = PadLoad;
        end else if (timer_q == '0) begin
          idx_d   = '0;
          state_d = StRead;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      StRead:  if (paused) state_d = StWrite;
`ifdef NVRAM_RESTORE_VERIFY_EN
      StWrite:  if (paused) state_d = StVerify;
      StVerify: state_d = StCheck;
      StCheck:  state_d = StNext;
`else
      StWrite:  if (paused) state_d = StNext;
`endif
      StNext: begin
        if (paused) begin
          if ({1'b0, idx_q} == dump_length_q - LenOne) begin
            timer_d = PadLoad;
            state_d = StRelease;
          end else begin
            idx_d   = idx_q + IdxOne;
            state_d = StRead;
          end
        end
      end
      StRelease: begin
        if (timer_q == '0) begin
          done_set = 1'b1;
          state_d  = StIdle;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // A fresh dump download abandons whatever restore is in flight.
    if (dl_start && (state_q != StIdle)) begin
      state_d  = StIdle;
      done_set = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      if (dl_start)      done_q <= 1'b0;
      else if (done_set) done_q <= 1'b1;
    end
  end

`ifdef NVRAM_RESTORE_VERIFY_EN
  logic verr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      verr_q <= 1'b0;
    end else if (dl_start) begin
      verr_q <= 1'b0;
    end else if ((state_q == StCheck) && (nvram_data_out != buf_q)) begin
      verr_q <= 1'b1;
    end
  end
  assign verify_error = verr_q;
`else
  logic unused_data_out;
  assign unused_data_out = ^nvram_data_out;
  assign verify_error    = 1'b0;
`endif

  assign pause_cpu     = (state_q != StIdle) && (state_q != StDelay);
  assign nvram_write   = (state_q == StWrite) && paused;
  assign nvram_address = idx_q;
  assign nvram_data_in = nvram_write ? buf_q : 8'd0;
  assign restore_done  = done_q;

endmodule

// File: tb/tb_nvram_restore.sv
// Directed bench for nvram_restore: download, restore ordering/timing, gaps, pause stalls,
// reset retry, abort and verify flag.
module tb_nvram_restore;

  localparam int PAUSEPAD   = 4;
  localparam int STARTDELAY = 16;
`ifdef NVRAM_RESTORE_VERIFY_EN
  localparam bit VerifyOn = 1'b1;
`else
  localparam bit VerifyOn = 1'b0;
`endif
  localparam int PerByte = VerifyOn ? 5 : 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        paused;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [7:0]  nvram_address, nvram_data_in, nvram_data_out;
  logic        nvram_write, pause_cpu, restore_done, verify_error;

  nvram_restore #(
    .DUMPWIDTH (8),
    .DUMPINDEX (4),
    .PAUSEPAD  (PAUSEPAD),
    .STARTDELAY(STARTDELAY)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .paused        (paused),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_index   (ioctl_index),
    .ioctl_dout    (ioctl_dout),
    .nvram_address (nvram_address),
    .nvram_data_in (nvram_data_in),
    .nvram_write   (nvram_write),
    .nvram_data_out(nvram_data_out),
    .pause_cpu     (pause_cpu),
    .restore_done  (restore_done),
    .verify_error  (verify_error)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: paused echoes pause_cpu two cycles later unless held low.
  logic [1:0] echo_q = 2'b00;
  logic       hold_low;
  always @(posedge clk) echo_q <= {echo_q[0], pause_cpu};
  assign paused = hold_low ? 1'b0 : echo_q[1];

  // Game RAM model with registered read; force_ff corrupts the read-back of byte 2.
  logic [7:0] nv_mem [256];
  logic [7:0] nv_dout = 8'd0;
  logic       force_ff;
  always @(posedge clk) begin
    if (nvram_write) nv_mem[nvram_address] <= nvram_data_in;
    nv_dout <= (force_ff && nvram_address == 8'd2) ? 8'hFF : nv_mem[nvram_address];
  end
  assign nvram_data_out = nv_dout;

  // Strobe and edge log.
  logic [7:0] wr_addr_log [1024];
  logic [7:0] wr_data_log [1024];
  int         wr_cyc_log  [1024];
  int         wr_total = 0, bad_strobes = 0;
  int         rise_cyc = 0, fall_cyc = 0, done_cyc = 0;
  logic       pause_prev = 1'b0, done_prev = 1'b0;
  always @(negedge clk) begin
    if (nvram_write) begin
      wr_addr_log[wr_total] = nvram_address;
      wr_data_log[wr_total] = nvram_data_in;
      wr_cyc_log[wr_total]  = cyc;
      if (!(pause_cpu && paused)) bad_strobes++;
      wr_total++;
    end
    if (pause_cpu && !pause_prev) rise_cyc = cyc;
    if (!pause_cpu && pause_prev) fall_cyc = cyc;
    if (restore_done && !done_prev) done_cyc = cyc;
    pause_prev = pause_cpu;
    done_prev  = restore_done;
  end

  int         errors = 0, checks = 0;
  logic [7:0] exp_data [16];
  int         base, base2, dl_end_cyc, rel_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dl_begin();
    @(negedge clk);
    ioctl_index    = 8'd4;
    ioctl_download = 1'b1;
  endtask

  task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b0;
  endtask

  task automatic dl_finish();
    @(negedge clk);
    ioctl_download = 1'b0;
    dl_end_cyc     = cyc;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000 && !restore_done; i++) @(negedge clk);
    chk(tag, restore_done, 1);
    @(negedge clk);
  endtask

  task automatic wait_strobes(input int from, input int n);
    for (int i = 0; i < 2000 && (wr_total - from) < n; i++) @(negedge clk);
  endtask

  // Every restore here covers addresses 0..n-1 in order.
  task automatic chk_strobes(input string tag, input int from, input int n);
    chk($sformatf("%s_count", tag), wr_total - from, n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_addr_log[from+i], i);
      chk($sformatf("%s_data%0d", tag, i), wr_data_log[from+i], exp_data[i]);
    end
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_index = 8'd0; ioctl_dout = 8'd0; hold_low = 1'b0; force_ff = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_write", nvram_write, 0);
    chk("rst_pause", pause_cpu, 0);
    chk("rst_addr", nvram_address, 0);
    chk("rst_data", nvram_data_in, 0);
    chk("rst_done", restore_done, 0);
    chk("rst_verify", verify_error, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_no_pause", pause_cpu, 0);

    // Basic 4-byte restore with timing.
    base = wr_total;
    dl_begin();
    dl_byte(25'd0, 8'h11); dl_byte(25'd1, 8'h22); dl_byte(25'd2, 8'h33); dl_byte(25'd3, 8'h44);
    dl_finish();
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33; exp_data[3] = 8'h44;
    wait_done("t1_done");
    chk("t1_pause_low", pause_cpu, 0);
    chk("t1_verify", verify_error, 0);
    chk_strobes("t1", base, 4);
    // Falling download edge seen next edge, IDLE->DELAY the edge after, then STARTDELAY+1 in DELAY.
    chk("t1_start_delay", rise_cyc - dl_end_cyc, STARTDELAY + 3);
    chk("t1_first_lat", wr_cyc_log[base] - rise_cyc, 2 + PAUSEPAD + 1);
    chk("t1_byte_gap", wr_cyc_log[base+1] - wr_cyc_log[base], PerByte);
    chk("t1_release_gap", fall_cyc - wr_cyc_log[base+3], PerByte + PAUSEPAD - 1);
    chk("t1_done_with_fall", done_cyc, fall_cyc);

    // Full 10-byte dump, then a gapped dump reusing the old buffer contents.
    base = wr_total;
    dl_begin();
    for (int i = 0; i < 10; i++) dl_byte(25'(i), 8'hA0 + 8'(i));
    dl_finish();
    for (int i = 0; i < 10; i++) exp_data[i] = 8'hA0 + 8'(i);
    wait_done("t2a_done");
    chk_strobes("t2a", base, 10);

    base = wr_total;
    dl_begin();
    dl_byte(25'd0, 8'h5A);
    dl_byte(25'h100, 8'hEE);
    dl_byte(25'd9, 8'hC3);
    dl_finish();
    exp_data[0] = 8'h5A; exp_data[9] = 8'hC3;
    wait_done("t2b_done");
    chk_strobes("t2b", base, 10);

    // paused held low for 50 cycles after pause_cpu rises.
    hold_low = 1'b1;
    base = wr_total;
    dl_begin(); dl_byte(25'd0, 8'h01); dl_byte(25'd1, 8'h02); dl_finish();
    for (int i = 0; i < 500 && !pause_cpu; i++) @(negedge clk);
    chk("t3_pause_up", pause_cpu, 1);
    repeat (50) @(negedge clk);
    chk("t3_no_strobe_held", wr_total - base, 0);
    chk("t3_pause_held", pause_cpu, 1);
    hold_low = 1'b0;
    rel_cyc  = cyc;
    exp_data[0] = 8'h01; exp_data[1] = 8'h02;
    wait_done("t3_done");
    chk_strobes("t3", base, 2);
    // Strobe falls in the (PAUSEPAD+2)-th cycle counting the paused-rise cycle as the first.
    chk("t3_first_lat", wr_cyc_log[base] - rel_cyc, PAUSEPAD + 1);

    // Reset after two writes; the restore restarts from byte 0.
    base = wr_total;
    dl_begin();
    dl_byte(25'd0, 8'h61); dl_byte(25'd1, 8'h62); dl_byte(25'd2, 8'h63); dl_byte(25'd3, 8'h64);
    dl_finish();
    wait_strobes(base, 2);
    chk("t4_two_written", wr_total - base, 2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t4_rst_pause", pause_cpu, 0);
    chk("t4_rst_write", nvram_write, 0);
    chk("t4_rst_addr", nvram_address, 0);
    chk("t4_rst_done", restore_done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base = wr_total;
    exp_data[0] = 8'h61; exp_data[1] = 8'h62; exp_data[2] = 8'h63; exp_data[3] = 8'h64;
    wait_done("t4_done");
    chk_strobes("t4", base, 4);

    // Abort by starting a new dump download mid-restore.
    base = wr_total;
    dl_begin();
    dl_byte(25'd0, 8'h71); dl_byte(25'd1, 8'h72); dl_byte(25'd2, 8'h73); dl_byte(25'd3, 8'h74);
    dl_finish();
    wait_strobes(base, 1);
    @(negedge clk);
    ioctl_download = 1'b1;
    @(negedge clk);
    chk("t5_abort_pause", pause_cpu, 0);
    chk("t5_abort_done", restore_done, 0);
    base2 = wr_total;
    dl_byte(25'd0, 8'h81); dl_byte(25'd1, 8'h82);
    repeat (10) @(negedge clk);
    chk("t5_no_strobe_after_abort", wr_total - base2, 0);
    dl_finish();
    exp_data[0] = 8'h81; exp_data[1] = 8'h82;
    wait_done("t5_done");
    chk_strobes("t5", base2, 2);

    // Corrupted read-back of byte 2 flags verify_error only when verification is built in.
    force_ff = 1'b1;
    base = wr_total;
    dl_begin();
    dl_byte(25'd0, 8'h91); dl_byte(25'd1, 8'h92); dl_byte(25'd2, 8'h93); dl_byte(25'd3, 8'h94);
    dl_finish();
    exp_data[0] = 8'h91; exp_data[1] = 8'h92; exp_data[2] = 8'h93; exp_data[3] = 8'h94;
    wait_done("t6_done");
    chk_strobes("t6", base, 4);
    chk("t6_verify_error", verify_error, VerifyOn ? 1 : 0);
    force_ff = 1'b0;

    chk("strobe_only_when_paused", bad_strobes, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
